// File: rtl/qpsk_mapper_if.sv
// Bit-in / symbol-out handshake bundle for qpsk_mapper.
// slave is the mapper's view, master is the neighbour's view.
interface qpsk_mapper_if #(
    parameter int IQ_W = 16
);
    logic                   valid_in;
    logic                   data_in;
    logic [8:0]             data_in_index;
    logic                   ready_mod;
    logic                   ready_ds;
    logic                   valid_out;
    logic signed [IQ_W-1:0] i_out;
    logic signed [IQ_W-1:0] q_out;
    logic [7:0]             sym_index;
    logic                   sym_last;

    modport slave (
        input  valid_in, data_in, data_in_index, ready_ds,
        output ready_mod, valid_out, i_out, q_out, sym_index, sym_last
    );

    modport master (
        output valid_in, data_in, data_in_index, ready_ds,
        input  ready_mod, valid_out, i_out, q_out, sym_index, sym_last
    );
endinterface

// File: rtl/qpsk_mapper.sv
// WiMAX QPSK mapper: ping-pong reassembly of indexed bits, then I/Q symbol stream.
// Optional MOD_BLOCK_CNT_EN adds a 16-bit count of blocks taken downstream.
module qpsk_mapper #(
    parameter int NCBPS = 192,
    parameter int IQ_W  = 16,
    parameter int AMP   = 23170
) (
    input  logic           clk,
    input  logic           resetN,
    qpsk_mapper_if.slave   bus,
    output logic           idx_err
`ifdef MOD_BLOCK_CNT_EN
    ,
    output logic [15:0]    block_cnt
`endif
);
    localparam int AW = $clog2(NCBPS);
    localparam int PW = $clog2(NCBPS / 2);
    localparam logic [9:0] NB = 10'(NCBPS);
    localparam logic [PW-1:0] LAST = PW'(NCBPS / 2 - 1);
    localparam logic signed [IQ_W-1:0] POS = IQ_W'(AMP);
    localparam logic signed [IQ_W-1:0] NEG = IQ_W'(-AMP);

    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_nx;

    logic [NCBPS-1:0] bank [2];
    logic [1:0]       full;
    logic             wr_bank;
    logic             rd_bank;
    logic [9:0]       wr_cnt;
    logic [PW-1:0]    rd_ptr;

    logic accept, in_rng, wr_done;
    logic load, rd_rel;
    logic bit_i, bit_q;

    assign bus.ready_mod = !full[wr_bank];
    assign accept  = bus.valid_in && bus.ready_mod;
    assign in_rng  = {1'b0, bus.data_in_index} < NB;
    assign wr_done = accept && in_rng && (wr_cnt == NB - 10'd1);
    assign bit_i   = bank[rd_bank][{rd_ptr, 1'b0}];
    assign bit_q   = bank[rd_bank][{rd_ptr, 1'b1}];

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        rd_rel   = 1'b0;
        unique case (state)
            IDLE: if (full[rd_bank]) state_nx = SEND;
            SEND: begin
                load = !bus.valid_out || bus.ready_ds;
                if (load && rd_ptr == LAST) begin
                    rd_rel   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= IDLE;
        else         state <= state_nx;
    end

    // rd_bank trails wr_bank so it always names the oldest unread block
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bank[0] <= '0;
            bank[1] <= '0;
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            idx_err <= 1'b0;
        end else begin
            if (accept && !in_rng) idx_err <= 1'b1;
            if (accept && in_rng) begin
                bank[wr_bank][bus.data_in_index[AW-1:0]] <= bus.data_in;
                wr_cnt <= wr_done ? '0 : wr_cnt + 10'd1;
            end
            if (wr_done) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= !wr_bank;
            end
            if (rd_rel) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= !rd_bank;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rd_ptr        <= '0;
            bus.valid_out <= 1'b0;
            bus.i_out     <= '0;
            bus.q_out     <= '0;
            bus.sym_index <= '0;
            bus.sym_last  <= 1'b0;
        end else if (load) begin
            bus.valid_out <= 1'b1;
            bus.i_out     <= bit_i ? NEG : POS;
            bus.q_out     <= bit_q ? NEG : POS;
            bus.sym_index <= 8'(rd_ptr);
            bus.sym_last  <= (rd_ptr == LAST);
            rd_ptr        <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
        end else if (bus.ready_ds) begin
            bus.valid_out <= 1'b0;
        end
    end

`ifdef MOD_BLOCK_CNT_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            block_cnt <= '0;
        else if (bus.valid_out && bus.ready_ds && bus.sym_last)
            block_cnt <= block_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_qpsk_mapper.sv
// Self-checking bench for qpsk_mapper: vector table, directed corner cases,
// randomized traffic scored against a block-image reference model.
module tb_qpsk_mapper;
    localparam int NCBPS = 192;
    localparam int NSYM  = NCBPS / 2;
    localparam int AMP   = 23170;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic idx_err;
`ifdef MOD_BLOCK_CNT_EN
    logic [15:0] block_cnt;
`endif

    qpsk_mapper_if #(.IQ_W(16)) bus ();

    qpsk_mapper #(.NCBPS(NCBPS), .IQ_W(16), .AMP(AMP)) dut (
        .clk(clk),
        .resetN(resetN),
        .bus(bus),
        .idx_err(idx_err)
`ifdef MOD_BLOCK_CNT_EN
        ,
        .block_cnt(block_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int i;
        int q;
        int idx;
        bit last;
    } sym_t;

    typedef struct {
        bit bi;
        bit bq;
        int ei;
        int eq;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    sym_t expq[$];
    bit   img[2][NCBPS];
    int   mwr = 0;
    int   mcnt = 0;
    int   nblk_done = 0;
    int   mblk = 0;
    bit   rdone;
    vec_t tbl[4];

    bit                 hold_p = 1'b0;
    logic signed [15:0] p_i, p_q;
    logic [7:0]         p_idx;
    logic               p_last;
    sym_t               e;
    bit                 ok;

    function automatic void chk(string name, logic signed [31:0] act,
                                logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    // Reference: each completed block is turned into its symbol list at once
    function automatic void model_bit(int idx, bit d);
        if (idx >= NCBPS) return;
        img[mwr][idx] = d;
        mcnt++;
        if (mcnt == NCBPS) begin
            for (int n = 0; n < NSYM; n++) begin
                sym_t s;
                s.i    = img[mwr][2*n]   ? -AMP : AMP;
                s.q    = img[mwr][2*n+1] ? -AMP : AMP;
                s.idx  = n;
                s.last = (n == NSYM - 1);
                expq.push_back(s);
            end
            mcnt = 0;
            mwr  = 1 - mwr;
            nblk_done++;
        end
    endfunction

    function automatic void model_reset();
        expq.delete();
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < NCBPS; k++) img[b][k] = 1'b0;
        mwr  = 0;
        mcnt = 0;
        mblk = 0;
    endfunction

    always @(negedge clk) begin
        if (!resetN) begin
            hold_p = 1'b0;
        end else begin
            if (hold_p) begin
                checks++;
                if (!(bus.valid_out === 1'b1 && bus.i_out === p_i &&
                      bus.q_out === p_q && bus.sym_index === p_idx &&
                      bus.sym_last === p_last)) begin
                    errors++;
                    $display("FAIL hold now v=%0b i=%0d q=%0d n=%0d held i=%0d q=%0d n=%0d",
                             bus.valid_out, bus.i_out, bus.q_out, bus.sym_index,
                             p_i, p_q, p_idx);
                end
            end
            if (bus.valid_out && bus.ready_ds) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sym unexpected n=%0d required none", bus.sym_index);
                end else begin
                    e = expq.pop_front();
                    checks++;
                    ok = (bus.i_out === 16'(e.i)) && (bus.q_out === 16'(e.q)) &&
                         (bus.sym_index === 8'(e.idx)) && (bus.sym_last === e.last);
                    if (!ok) begin
                        errors++;
                        $display("FAIL sym got i=%0d q=%0d n=%0d l=%0b required i=%0d q=%0d n=%0d l=%0b",
                                 bus.i_out, bus.q_out, bus.sym_index, bus.sym_last,
                                 e.i, e.q, e.idx, e.last);
                    end
                    if (e.last) mblk++;
                end
            end
            if (bus.valid_in && bus.ready_mod)
                model_bit(int'(bus.data_in_index), bus.data_in);
            hold_p = bus.valid_out && !bus.ready_ds;
            p_i    = bus.i_out;
            p_q    = bus.q_out;
            p_idx  = bus.sym_index;
            p_last = bus.sym_last;
        end
    end

    // Called at posedge+1; returns at posedge+1 right after acceptance
    task automatic send_bit(input int idx, input bit d);
        int n;
        n = 0;
        bus.valid_in      = 1'b1;
        bus.data_in       = d;
        bus.data_in_index = idx[8:0];
        @(negedge clk);
        while (!bus.ready_mod && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL send_timeout idx=%0d ready_mod=%0b required 1", idx, bus.ready_mod);
        end
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
    endtask

    task automatic send_fixed(input bit bi, input bit bq);
        for (int k = 0; k < NCBPS; k++) send_bit(k, (k % 2 == 1) ? bq : bi);
    endtask

    task automatic send_perm();
        for (int k = 0; k < NCBPS; k++) send_bit(12 * (k % 16) + k / 16, k[0]);
    endtask

    task automatic send_rand(input bit rnd_idx, input bit gaps);
        int idx;
        for (int k = 0; k < NCBPS; k++) begin
            idx = rnd_idx ? int'($urandom_range(0, NCBPS - 1)) : k;
            send_bit(idx, 1'($urandom_range(0, 1)));
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.ready_ds = 1'b1;
        while ((expq.size() != 0 || bus.valid_out) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", expq.size(), 0);
        chk("drain_valid", bus.valid_out, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sym(input int idx);
        int n;
        n = 0;
        @(negedge clk);
        while (!(bus.valid_out && bus.sym_index == idx) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_sym", bus.sym_index, idx);
    endtask

    task automatic bp_watch(input int base);
        int n;
        n = 0;
        while (bus.ready_mod && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("bp_ready_low", bus.ready_mod, 0);
        chk("bp_blocks_at_fall", nblk_done - base, 2);
        repeat (300) @(negedge clk);
        chk("bp_ready_held", bus.ready_mod, 0);
        @(posedge clk);
        #1;
        bus.ready_ds = 1'b1;
    endtask

    task automatic rand_ready();
        while (!rdone) begin
            @(posedge clk);
            #1;
            bus.ready_ds = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, bus.valid_out, 0);
        chk({tag, "_i"}, bus.i_out, 0);
        chk({tag, "_q"}, bus.q_out, 0);
        chk({tag, "_idx"}, bus.sym_index, 0);
        chk({tag, "_last"}, bus.sym_last, 0);
        chk({tag, "_ready"}, bus.ready_mod, 1);
        chk({tag, "_idx_err"}, idx_err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        bus.valid_in      = 1'b0;
        bus.data_in       = 1'b0;
        bus.data_in_index = '0;
        bus.ready_ds      = 1'b0;
        tbl[0] = '{1'b0, 1'b0,  AMP,  AMP};
        tbl[1] = '{1'b1, 1'b0, -AMP,  AMP};
        tbl[2] = '{1'b0, 1'b1,  AMP, -AMP};
        tbl[3] = '{1'b1, 1'b1, -AMP, -AMP};
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        resetN = 1'b1;
        @(posedge clk);
        #1;

        // Constellation points, first-symbol latency
        for (int v = 0; v < 4; v++) begin
            bus.ready_ds = 1'b1;
            send_fixed(tbl[v].bi, tbl[v].bq);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.valid_out && n < 10);
            chk("latency", n, 3);
            chk("first_i", bus.i_out, tbl[v].ei);
            chk("first_q", bus.q_out, tbl[v].eq);
            chk("first_idx", bus.sym_index, 0);
            drain();
        end

        send_perm();
        drain();

        // Out-of-range index is dropped and does not count
        send_bit(200, 1'b1);
        chk("oor_err", idx_err, 1);
        for (int k = 0; k < NCBPS - 1; k++) send_bit(k, 1'(k / 3));
        repeat (5) @(negedge clk);
        chk("oor_not_complete", bus.valid_out, 0);
        @(posedge clk);
        #1;
        send_bit(NCBPS - 1, 1'b1);
        drain();
        chk("oor_sticky", idx_err, 1);

        // Random data, duplicate indices, gaps and random backpressure
        rdone = 1'b0;
        fork
            begin
                send_rand(1'b0, 1'b1);
                send_rand(1'b1, 1'b1);
                send_rand(1'b0, 1'b1);
                send_rand(1'b1, 1'b0);
                rdone = 1'b1;
            end
            rand_ready();
        join
        drain();

        // Long backpressure across three blocks
        bus.ready_ds = 1'b0;
        base = nblk_done;
        fork
            begin
                send_rand(1'b0, 1'b0);
                send_rand(1'b0, 1'b0);
                send_rand(1'b0, 1'b0);
            end
            bp_watch(base);
        join
        drain();

        // Reset during symbol 40 with the next block half written
        bus.ready_ds = 1'b0;
        send_rand(1'b0, 1'b0);
        for (int k = 0; k < NCBPS / 2; k++) send_bit(k, 1'b1);
        bus.ready_ds = 1'b1;
        wait_sym(40);
        #2;
        resetN = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        resetN = 1'b1;
        send_rand(1'b0, 1'b0);
        drain();

`ifdef MOD_BLOCK_CNT_EN
        send_fixed(1'b0, 1'b1);
        drain();
        chk("block_cnt_2", block_cnt, 2);
        bus.ready_ds = 1'b0;
        send_fixed(1'b1, 1'b1);
        bus.ready_ds = 1'b1;
        wait_sym(NSYM - 2);
        @(posedge clk);
        #1;
        bus.ready_ds = 1'b0;
        repeat (5) @(negedge clk);
        chk("cnt_hold_last", bus.sym_last, 1);
        chk("cnt_hold", block_cnt, 2);
        drain();
        chk("block_cnt_3", block_cnt, 3);
        chk("block_cnt_model", block_cnt, mblk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/qpsk_mapper.md
Name: qpsk_mapper

Overview:
- Downstream neighbour of the interleaver in the WiMAX PHY transmit chain.
- Accepts one interleaved bit per cycle, tagged with its destination index, and reassembles each 192-bit block in a ping-pong buffer.
- Once a block is complete, emits 96 QPSK symbols in index order as signed fixed-point I/Q samples toward the IFFT/subcarrier-mapping stage.
- Drives the ready_mod handshake back to the interleaver.

Parameters:
- NCBPS, 192, coded bits per block (must be even, at most 512)
- IQ_W, 16, width of signed I/Q outputs
- AMP, 23170, symbol amplitude magnitude (0.7071 in Q1.15)

Ports:
- clk  input  1  clock, rising edge
- resetN  input  1  asynchronous active-low reset
- valid_in  input  1  bit valid from interleaver (valid_interleaver)
- data_in  input  1  interleaved bit
- data_in_index  input  9  destination bit index of data_in, 0..NCBPS-1
- ready_mod  output  1  ready to accept a bit
- ready_ds  input  1  downstream ready
- valid_out  output  1  symbol valid
- i_out  output  IQ_W  signed in-phase sample
- q_out  output  IQ_W  signed quadrature sample
- sym_index  output  8  symbol position in block, 0..NCBPS/2-1
- sym_last  output  1  high with the final symbol of a block
- idx_err  output  1  sticky, index out of range seen

Behaviour:
- Reset: resetN is asynchronous, active-low; clock is clk. On reset, all outputs are 0, both banks are empty, wr_bank=0, write count=0, read FSM=IDLE. Reset mid-block discards any partial or full bank contents.
- Storage: two NCBPS-bit banks. The write side owns bank wr_bank; the read side owns the other bank while it is full.
- Bit acceptance: a bit is accepted when valid_in && ready_mod. Bank[wr_bank][data_in_index] <= data_in, and the write count increments.
- Out-of-range index: if data_in_index >= NCBPS, the bit is dropped, not counted, and idx_err is set. idx_err clears only on reset.
- Block completion: the accepted bit that brings the count to NCBPS marks bank wr_bank full, toggles wr_bank, and wraps the count to 0 in the same edge.
- Bits are counted, not index-checked. A block completes after NCBPS accepted bits regardless of duplicate indices. A duplicate index overwrites the earlier bit; positions never written keep their previous value.
- ready_mod = !(bank[wr_bank] full), combinational from registered state. It is low only when both banks are full, i.e. the read side has not drained the older block. The bank released by the read side on an edge is writable from the next cycle.
- Read FSM, IDLE: if the non-write bank is full, go to SEND with rd_ptr=0.
- Read FSM, SEND: the output register loads when !valid_out || ready_ds.
  - Symbol n uses bits 2n (I) and 2n+1 (Q).
  - Bit 0 maps to +AMP; bit 1 maps to -AMP (two's complement, IQ_W bits).
  - sym_index=n; sym_last=(n==NCBPS/2-1).
- Block release: when the last symbol is loaded, the bank is released (full cleared) and the FSM returns to IDLE. If the other bank is already full, the FSM goes straight back to SEND, with no bubble beyond one cycle.
- Output hold: valid_out, i_out, q_out, sym_index and sym_last stay stable while valid_out && !ready_ds. valid_out drops after the last symbol is taken if no next symbol is loaded.
- Latency: the NCBPS-th bit is accepted at edge E. Bank full is visible at E, the FSM enters SEND at E+1, and the first symbol is valid after E+2.
- Throughput: with ready_ds held high, 96 symbols on consecutive cycles per block.
- Simultaneous events: completing a write bank and releasing the read bank on the same edge is legal. Both state updates take effect, and the next block is read without loss.

Optional Feature:
- Macro: MOD_BLOCK_CNT_EN.
- Defined:
  - Adds output block_cnt [15:0], reset to 0.
  - Increments when a sym_last symbol is accepted downstream (valid_out && ready_ds && sym_last).
  - Wraps from 65535 to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Identity block: indices 0..191 in order, data all 0, ready_ds=1 -> 96 symbols, i_out=q_out=+23170, sym_index 0..95, sym_last only at 95; first valid_out two cycles after the edge accepting bit 191.
- Interleaver-order block: indices from the WiMAX QPSK permutation j(k), data_in = k[0] -> output bit pattern matches a reference deinterleave. Symbol n bits (2n,2n+1) give I=-23170 when bit=1, otherwise +23170.
- Backpressure: ready_ds=0 for 300 cycles while three blocks are streamed -> ready_mod falls after the second block completes. Outputs are held stable, no bits are lost, and all 288 symbols are correct after ready_ds=1.
- Out-of-range: one bit with data_in_index=200 -> idx_err=1 and sticky, bit not counted; the block completes after 192 further valid bits.
- Reset mid-operation: resetN low during symbol 40 of block 1 with block 2 half written -> all outputs 0, ready_mod=1; the next full block is emitted correctly from sym_index 0.
- MOD_BLOCK_CNT_EN: 3 complete blocks drained -> block_cnt=3; counter stays unchanged while sym_last is held with ready_ds=0.
